// File: rtl/cpu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_exec_unit
// Description : Multi-cycle execute/writeback datapath with an issue
//               handshake. It holds a register bank, op2 mux, ALU, carry/zero
//               flags, a result register and a 4-way writeback source mux.
//               Sequence: IDLE -> EXEC -> [WAIT] -> WB -> IDLE.
// Ports       : clk_i/rst_i/clkEn_i   clock, sync active-high reset, enable
//               issue_valid_i/_ready_o   instruction handshake
//               rs_sel_i, rs2_sel_i, rd_sel_i, immed_i, op2_c_i, ALUOp_c_i,
//               RegMux_c_i, flag_we_i    decoded instruction fields
//               data_req_o/data_ack_i/data_dat_i   data-memory read handshake
//               port_dat_i               input-port data
//               rs_o                     latched R[rs] (memory/port address)
//               carry_o, zero_o          flag registers
//               done_o                   one-cycle pulse in the writeback cycle
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_exec_unit #(
    parameter int DATA_W  = 8,
    parameter int REG_CNT = 8,
    parameter int RA_W    = $clog2(REG_CNT)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clkEn_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [RA_W-1:0]   rs_sel_i,
    input  logic [RA_W-1:0]   rs2_sel_i,
    input  logic [RA_W-1:0]   rd_sel_i,
    input  logic [DATA_W-1:0] immed_i,
    input  logic              op2_c_i,
    input  logic [3:0]        ALUOp_c_i,
    input  logic [1:0]        RegMux_c_i,
    input  logic              flag_we_i,
    output logic              data_req_o,
    input  logic              data_ack_i,
    input  logic [DATA_W-1:0] data_dat_i,
    input  logic [DATA_W-1:0] port_dat_i,
    output logic [DATA_W-1:0] rs_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              done_o
);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_ADDC = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_SUBC = 4'd3;
    localparam logic [3:0] c_OP_AND  = 4'd4;
    localparam logic [3:0] c_OP_OR   = 4'd5;
    localparam logic [3:0] c_OP_XOR  = 4'd6;
    localparam logic [3:0] c_OP_PASS = 4'd7;
    localparam logic [3:0] c_OP_SHL  = 4'd8;
    localparam logic [3:0] c_OP_SHR  = 4'd9;
    localparam logic [3:0] c_OP_RL   = 4'd10;
    localparam logic [3:0] c_OP_RR   = 4'd11;
    localparam logic [3:0] c_OP_CMP  = 4'd12;

    localparam logic [1:0] c_MUX_ALU  = 2'b00;
    localparam logic [1:0] c_MUX_DATA = 2'b01;
    localparam logic [1:0] c_MUX_PORT = 2'b10;
    localparam logic [1:0] c_MUX_NONE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_regs [REG_CNT];
    logic [DATA_W-1:0]   r_op2;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_ldata;
    logic [3:0]          r_op;
    logic [1:0]          r_mux;
    logic [RA_W-1:0]     r_rd;
    logic                r_flag_we;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_alu_r;
    logic                w_alu_c;
    logic                w_alu_z;
    logic                w_flag_upd;
    logic [DATA_W-1:0]   w_wb_data;
    logic                w_wb_en;

    assign issue_ready_o = (r_state == S_IDLE);

    // ALU operates only on operands latched at issue, never on live registers.
    always_comb begin
        w_sum   = '0;
        w_alu_r = '0;
        w_alu_c = 1'b0;
        case (r_op)
            c_OP_ADD:  w_sum = {1'b0, rs_o} + {1'b0, r_op2};
            c_OP_ADDC: w_sum = {1'b0, rs_o} + {1'b0, r_op2} + {{DATA_W{1'b0}}, carry_o};
            c_OP_SUB,
            c_OP_CMP:  w_sum = {1'b0, rs_o} - {1'b0, r_op2};
            c_OP_SUBC: w_sum = {1'b0, rs_o} - {1'b0, r_op2} - {{DATA_W{1'b0}}, carry_o};
            default:   w_sum = '0;
        endcase
        case (r_op)
            c_OP_ADD, c_OP_ADDC, c_OP_SUB, c_OP_SUBC, c_OP_CMP: begin
                // Bit DATA_W of the extended difference is the borrow.
                w_alu_r = w_sum[DATA_W-1:0];
                w_alu_c = w_sum[DATA_W];
            end
            c_OP_AND:  w_alu_r = rs_o & r_op2;
            c_OP_OR:   w_alu_r = rs_o | r_op2;
            c_OP_XOR:  w_alu_r = rs_o ^ r_op2;
            c_OP_PASS: w_alu_r = r_op2;
            c_OP_SHL: begin
                w_alu_r = {rs_o[DATA_W-2:0], 1'b0};
                w_alu_c = rs_o[DATA_W-1];
            end
            c_OP_SHR: begin
                w_alu_r = {1'b0, rs_o[DATA_W-1:1]};
                w_alu_c = rs_o[0];
            end
            c_OP_RL: begin
                w_alu_r = {rs_o[DATA_W-2:0], rs_o[DATA_W-1]};
                w_alu_c = rs_o[DATA_W-1];
            end
            c_OP_RR: begin
                w_alu_r = {rs_o[0], rs_o[DATA_W-1:1]};
                w_alu_c = rs_o[0];
            end
            default: begin
                w_alu_r = '0;
                w_alu_c = 1'b0;
            end
        endcase
        // Carry-chained ops keep zero only if the earlier part was also zero,
        // so multi-word results test zero across all words.
        if (r_op == c_OP_ADDC || r_op == c_OP_SUBC)
            w_alu_z = (w_alu_r == '0) && zero_o;
        else
            w_alu_z = (w_alu_r == '0);
    end

    // Ops 13-15 never touch the flags, even with flag_we set.
    assign w_flag_upd = r_flag_we && (r_op <= c_OP_CMP);

    always_comb begin
        w_wb_data = r_result;
        case (r_mux)
            c_MUX_ALU:  w_wb_data = r_result;
            c_MUX_DATA: w_wb_data = r_ldata;
            c_MUX_PORT: w_wb_data = port_dat_i;
            default:    w_wb_data = r_result;
        endcase
    end

    assign w_wb_en = (r_mux != c_MUX_NONE) && (r_op != c_OP_CMP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
            r_op2      <= '0;
            r_result   <= '0;
            r_ldata    <= '0;
            r_op       <= '0;
            r_mux      <= '0;
            r_rd       <= '0;
            r_flag_we  <= 1'b0;
            rs_o       <= '0;
            carry_o    <= 1'b0;
            zero_o     <= 1'b0;
            data_req_o <= 1'b0;
            done_o     <= 1'b0;
        end else if (clkEn_i) begin
            case (r_state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (issue_valid_i) begin
                        rs_o      <= r_regs[rs_sel_i];
                        r_op2     <= op2_c_i ? r_regs[rs2_sel_i] : immed_i;
                        r_op      <= ALUOp_c_i;
                        r_mux     <= RegMux_c_i;
                        r_rd      <= rd_sel_i;
                        r_flag_we <= flag_we_i;
                        r_state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result <= w_alu_r;
                    if (w_flag_upd) begin
                        carry_o <= w_alu_c;
                        zero_o  <= w_alu_z;
                    end
                    if (r_mux == c_MUX_DATA) begin
                        data_req_o <= 1'b1;
                        r_state    <= S_WAIT;
                    end else begin
                        done_o  <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_WAIT: begin
                    if (data_ack_i) begin
                        r_ldata    <= data_dat_i;
                        data_req_o <= 1'b0;
                        done_o     <= 1'b1;
                        r_state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_wb_en) r_regs[r_rd] <= w_wb_data;
                    done_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_exec_unit.md
Name: cpu_exec_unit

Overview:
- Parametrised multi-cycle execute/writeback datapath for the CPU: register bank, op2 mux, ALU, carry/zero flag register, ALU result register and a 4-way writeback source mux.
- Adds an issue handshake and a sequencer FSM, so an instruction is accepted, executed, optionally waits on a data-memory handshake, then writes back.
- Data width and register count are generic. Sits between the instruction decoder/control unit (which supplies decoded fields) and the data memory/port bus.

Parameters:
- DATA_W, 8, datapath and register width (>=4).
- REG_CNT, 8, number of general registers (power of 2, >=2).
- RA_W, $clog2(REG_CNT), register index width (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clkEn_i  in  1  global enable; 0 freezes all state
- issue_valid_i  in  1  decoded instruction present
- issue_ready_o  out  1  block can accept (state IDLE)
- rs_sel_i  in  RA_W  source register index
- rs2_sel_i  in  RA_W  second source register index
- rd_sel_i  in  RA_W  destination register index
- immed_i  in  DATA_W  immediate operand
- op2_c_i  in  1  1: op2=R[rs2], 0: op2=immed
- ALUOp_c_i  in  4  ALU operation
- RegMux_c_i  in  2  writeback source: 00 ALU, 01 data_dat_i, 10 port_dat_i, 11 none
- flag_we_i  in  1  update carry/zero from this op
- data_req_o  out  1  data-memory read request
- data_ack_i  in  1  data-memory acknowledge, data valid
- data_dat_i  in  DATA_W  data-memory read data
- port_dat_i  in  DATA_W  input-port data
- rs_o  out  DATA_W  latched R[rs] value (memory/port address)
- carry_o  out  1  carry flag register
- zero_o  out  1  zero flag register
- done_o  out  1  one-cycle pulse on writeback cycle

Behaviour:
- Reset (sync, at the clock edge with rst_i=1):
  - all registers, flags, rs_o, result register <= 0; state <= IDLE.
  - data_req_o=0, done_o=0. issue_ready_o=1 (combinational from IDLE).
- clkEn_i=0: no state, register, flag or output change. Handshakes are not sampled. rst_i overrides clkEn_i.
- FSM IDLE -> EXEC -> [WAIT] -> WB -> IDLE.
- IDLE:
  - Accepts when issue_valid_i & issue_ready_o.
  - Latches control, rd, immed, R[rs] (drives rs_o) and R[rs2].
  - Operands are sampled here, so later writes do not affect the instruction in flight.
- EXEC:
  - ALU computes on the latched rs and op2; result goes to the result register.
  - If flag_we is latched, carry/zero update at the end of EXEC.
  - Next state is WAIT if RegMux=01, otherwise WB.
- WAIT:
  - data_req_o=1.
  - On data_ack_i=1, captures data_dat_i and goes to WB. An ack in the first WAIT cycle is valid.
  - No timeout.
  - data_ack_i outside WAIT is ignored.
- WB:
  - done_o=1.
  - Writes R[rd] from the selected source. RegMux=10 samples port_dat_i in this cycle. No write if RegMux=11 or op=CMP.
  - Next state IDLE.
- Latency and throughput:
  - Non-load: accept at cycle N, done_o at N+2.
  - Load: done_o at the ack cycle +1.
  - Maximum 1 instruction per 3 cycles.
- ALU ops, DATA_W-bit, c = carry flag:
  - 0 ADD: {co,r}=a+b
  - 1 ADDC: a+b+c
  - 2 SUB: a-b, co=borrow
  - 3 SUBC: a-b-c
  - 4 AND, 5 OR, 6 XOR: co=0
  - 7 PASS: r=b, co=0
  - 8 SHL: r={a[W-2:0],0}, co=a[W-1]
  - 9 SHR: r={0,a[W-1:1]}, co=a[0]
  - 10 RL: rotate left, co=a[W-1]
  - 11 RR: rotate right, co=a[0]
  - 12 CMP: as SUB, result discarded
  - 13-15: r=0, flags never updated
- Zero flag: zero=(r==0). For ADDC/SUBC, zero=(r==0)&previous zero.
- Register bank: combinational read, write on the WB edge only. Write to rd while the next instruction is not yet accepted causes no hazard.
- Mid-operation reset: FSM aborts from any state. data_req_o falls in the cycle after the reset edge; no writeback occurs.

Test Plan:
- Reset with R1=0x55: rst_i for 1 cycle -> R1=0, carry=0, zero=0, issue_ready_o=1, data_req_o=0.
- ADD R2=R0+0xFF then ADDC R2=R2+0x01 with flag_we:
  - done at N+2, R2=0xFF, carry=0.
  - Then R2=0x00, carry=1, zero=0, because the previous zero was 0.
- Load to R3 (RegMux=01) with ack delayed 3 cycles and data 0xA5 -> data_req_o high 3 cycles, R3=0xA5, done 1 cycle after ack, flags unchanged.
- CMP R4=0x10 vs immed 0x10 -> zero=1, carry=0, R4 unchanged; CMP 0x0F vs 0x10 -> carry=1, zero=0.
- clkEn_i=0 for 4 cycles mid-EXEC -> state, flags and result frozen; completes normally after re-enable with the same done_o timing offset by 4.
- rst_i asserted in WAIT -> data_req_o=0 next cycle, rd not written, an ack arriving after reset is ignored, next issue accepted.
